// File: rtl/router_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// router_port_arbiter_if
//   Channel bundle between the router input ports and one output link.
//
//   Handshake: a packet moves across a channel on a rising clk edge where its
//   valid and ready are both high. A requester holds req_data[i] stable while
//   req_valid[i] is high, and drops req_valid[i] only in cycles where
//   req_ready[i] is low. req_valid must not depend combinationally on req_ready.
//   The output holds out_valid/out_data until a clock edge with out_ready high.
//
//   Signals:
//     req_valid  [NREQ]        per-requester packet valid
//     req_data   [NREQ*WIDTH]  packets, requester i at [i*WIDTH +: WIDTH]
//     req_ready  [NREQ]        one-hot accept strobe from the arbiter
//     out_valid                output packet valid
//     out_data   [WIDTH]       output packet
//     out_ready                downstream accept
//
//   Modports: slave = arbiter side, master = requester/downstream side.
// -----------------------------------------------------------------------------
interface router_port_arbiter_if #(
  parameter int WIDTH = 33,
  parameter int NREQ  = 5
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data
  );
endinterface

// File: rtl/router_port_arbiter.sv
// -----------------------------------------------------------------------------
// router_port_arbiter
//   Round-robin arbiter sharing one router output link among NREQ input ports
//   (0=N, 1=E, 2=S, 3=W, 4=PE). In IDLE the first valid requester found from
//   the rotating pointer wins, its packet is registered and presented on the
//   output in SEND until downstream accepts it. One packet per two cycles max.
//
//   Optional feature macro: ARB_GRANT_CNT_EN
//     defined   -> per-requester saturating grant counters on grant_cnt
//     undefined -> no counter registers, grant_cnt tied to 0
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     bus          router_port_arbiter_if.slave (request and output channels)
//     grant_idx    [3]           index of the current / last winner
//     busy                       high while in SEND
//     grant_cnt    [NREQ*CNT_W]  grant counters, requester i at [i*CNT_W +: CNT_W]
//     dbg_state_o                FSM state (0=IDLE, 1=SEND)
//     dbg_ptr_o    [3]           round-robin pointer
// -----------------------------------------------------------------------------
module router_port_arbiter #(
  parameter int WIDTH = 33,
  parameter int NREQ  = 5,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  router_port_arbiter_if.slave    bus,
  output logic [2:0]              grant_idx,
  output logic                    busy,
  output logic [NREQ*CNT_W-1:0]   grant_cnt,
  output logic                    dbg_state_o,
  output logic [2:0]              dbg_ptr_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       grant_idx_q, grant_idx_d;

  logic [2:0]       ptr_eff;
  logic             any_valid;
  logic [2:0]       win_idx;
  int               cand;
  logic [WIDTH-1:0] win_data;
  logic             accept;

  // Pointer values past the last requester cannot be reached; map them to 0
  // so a corrupted pointer still yields a legal scan start.
  assign ptr_eff = (ptr_q > LAST_IDX) ? 3'd0 : ptr_q;

  // Rotating-priority scan: ptr_eff, ptr_eff+1, ... (mod NREQ).
  always_comb begin
    any_valid = 1'b0;
    win_idx   = 3'd0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_eff) + k) % NREQ;
      if (!any_valid && bus.req_valid[cand]) begin
        any_valid = 1'b1;
        win_idx   = 3'(cand);
      end
    end
  end

  assign win_data = bus.req_data[int'(win_idx)*WIDTH +: WIDTH];
  assign accept   = (state_q == IDLE) && any_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid)     state_d = SEND;
      SEND:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the state register, plus combinational grant)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) bus.req_ready[win_idx] = 1'b1;
      end
      SEND: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: captured packet, winner index and round-robin pointer.
  // All three only move on an accept edge, so they are stable through SEND.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_d  = out_data_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = win_data;
      grant_idx_d = win_idx;
      ptr_d       = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data = out_data_q;
  assign grant_idx    = grant_idx_q;
  assign dbg_state_o  = state_q;
  assign dbg_ptr_o    = ptr_q;

  // ---------------------------------------------------------------------------
  // Optional grant counters
  // ---------------------------------------------------------------------------
`ifdef ARB_GRANT_CNT_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at all-ones so a long-running port never appears to reset.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q[win_idx] != {CNT_W{1'b1}})) begin
      cnt_d[win_idx] = cnt_q[win_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: doc/router_port_arbiter.md
# router_port_arbiter

Clocked round-robin arbiter that shares one 5-port router output (N/E/S/W/PE) among the five input ports of the mesh router. Each input presents a 33-bit packet with a valid/ready handshake. The arbiter grants one requester, registers its packet, and drives it to the output channel. It sits between the router's route-computation stage and each output link, with one instance per output direction.

## Interface
- WIDTH, 33, packet width; bit 32 is the packet-type flag, bits 31:28 are the destination address, bits 27:0 are the payload (all carried opaquely).
- NREQ, 5, number of requesters; index 0=N, 1=E, 2=S, 3=W, 4=PE.
- CNT_W, 16, width of each grant counter (used only with ARB_GRANT_CNT_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester packet valid.
- req_data  in  NREQ*WIDTH  packets; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept strobe (combinational).
- out_valid  out  1  output packet valid.
- out_data  out  WIDTH  registered output packet.
- out_ready  in  1  downstream accept.
- grant_idx  out  3  index of the current or last winner (registered).
- busy  out  1  high while state is SEND.
- grant_cnt  out  NREQ*CNT_W  per-requester grant counters; driven to 0 without ARB_GRANT_CNT_EN.

## Operation
- FSM has two states: IDLE and SEND.
- **IDLE:**
  - The winner is the first i with req_valid[i] set, scanning ptr, ptr+1, …, ptr+4 (mod 5).
  - req_ready[winner] = 1 combinationally; all other bits are 0.
  - No requester valid: req_ready = 0 and the state stays IDLE.
- **Accept edge** (IDLE and any req_valid):
  - out_data <= req_data[winner]
  - grant_idx <= winner
  - ptr <= (winner+1) mod 5
  - state <= SEND
- **SEND:**
  - out_valid = 1 and req_ready = 0.
  - out_data and grant_idx are held stable.
  - On an edge with out_ready=1: state <= IDLE and the packet is consumed.
  - While out_ready=0 the packet is held indefinitely.
- **Requester rules:** req_data[i] is stable while req_valid[i] is high. Deasserting valid without a transfer is permitted only in cycles where req_ready[i]=0.
- **Round-robin state:** ptr is 3 bits, range 0..4, and wraps from 4 to 0. Values 5..7 are unreachable; if seen, treat as 0.
- **Fairness:** a continuously requesting port is granted within 5 grants.
- **Reset** (any time, including mid-SEND):
  - state=IDLE, ptr=0, out_valid=0, out_data=0, grant_idx=0, busy=0, req_ready=0, grant_cnt=0.
  - The in-flight packet is discarded.

## Timing
- Request-to-output latency is 1 cycle: accept at edge t, out_valid high after edge t.
- Minimum period per packet is 2 cycles (one IDLE arbitration cycle plus one SEND cycle). There is no back-to-back grant from SEND.
- out_valid and busy are decoded directly from the state register (glitch-free).
- req_ready is combinational from req_valid, ptr and state. Requesters must not make req_valid depend combinationally on req_ready.
- Simultaneous requests in one IDLE cycle: exactly one grant goes to the highest rotating priority; losers keep valid and compete again after the SEND completes.
- A new req_valid arriving while in SEND is ignored until the state returns to IDLE.

## Configuration
- Macro: ARB_GRANT_CNT_EN.
- **Defined:**
  - Each CNT_W-bit counter grant_cnt[i] increments on every accept edge where winner=i.
  - Counters saturate at all-ones (0xFFFF) and do not wrap.
  - Counters are cleared only by rst_n.
- **Undefined:** no counter registers exist and grant_cnt is tied to 0. All other behaviour is identical.

## Test plan
- **Single requester:** hold req_valid[0]=1 with data 33'h1_9ABC_DEF0 and out_ready=1.
  - req_ready[0] pulses in the IDLE cycle.
  - One cycle later out_valid=1, out_data=33'h1_9ABC_DEF0, grant_idx=0.
  - One packet is output every 2 cycles.
- **All five valid, out_ready=1:** grant order is 0,1,2,3,4,0 (ptr wraps from 4 to 0), and each requester's own data appears on out_data.
- **Backpressure:** with out_ready=0 for 10 cycles in SEND:
  - out_valid stays 1 and out_data/grant_idx stay unchanged.
  - req_ready stays 0.
  - Raising out_ready gives a transfer on that edge, then IDLE.
- **Rotation:** with ptr=3 and only ports 1 and 4 valid:
  - Port 4 wins and ptr becomes 0.
  - Next, port 1 wins and ptr becomes 2.
- **Reset mid-SEND:** pulse rst_n low asynchronously while out_valid=1 and out_ready=0.
  - Outputs clear immediately and ptr=0.
  - After release, port 0 has priority.
- **ARB_GRANT_CNT_EN** (run with the macro defined):
  - Grant port 2 seventy times: grant_cnt[2]=70 and all others 0.
  - Preload via a forced counter value of 0xFFFE, then grant twice: the counter stays at 0xFFFF.
